// File: rtl/spram_march_bist.sv
// March-C style self-test engine for the single-port SPRAM word interface.
// Optional macro SPRAM_BIST_SCRUB_EN: zero-fill the whole range after a passing run.
module spram_march_bist #(
  parameter int          WORDS   = 32768,
  parameter logic [31:0] PATTERN = 32'h5555_AAAA
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [21:0] fail_addr,
  output logic [31:0] fail_data,
  output logic [3:0]  mem_wen,
  output logic [21:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_W0    = 3'd1,
    S_R0W1  = 3'd2,
    S_R1W0  = 3'd3,
    S_R0    = 3'd4,
`ifdef SPRAM_BIST_SCRUB_EN
    S_SCRUB = 3'd5,
`endif
    S_DONE  = 3'd6
  } state_e;

  localparam logic [14:0] LAST = 15'(WORDS - 1);

  state_e      state_q;
  logic        chk_q;
  logic [14:0] addr_q;
  logic        busy_q;
  logic        done_q;
  logic        fail_q;
  logic [21:0] fail_addr_q;
  logic [31:0] fail_data_q;
  logic [3:0]  wen_q;
  logic [31:0] wdata_q;

  logic [31:0] expect_d;
  logic        in_read_d;
  logic        mismatch_d;

  // Compare the returned word against the background of the current element.
  always_comb begin
    expect_d   = 32'h0;
    in_read_d  = 1'b0;
    mismatch_d = 1'b0;
    if (state_q == S_R1W0) begin
      expect_d = ~PATTERN;
    end else begin
      expect_d = PATTERN;
    end
    if ((state_q == S_R0W1) || (state_q == S_R1W0) || (state_q == S_R0)) begin
      in_read_d = 1'b1;
    end else begin
      in_read_d = 1'b0;
    end
    if (in_read_d && chk_q && (mem_rdata != expect_d)) begin
      mismatch_d = 1'b1;
    end else begin
      mismatch_d = 1'b0;
    end
  end

  // Sequencer: march elements, address stepping and result capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      chk_q       <= 1'b0;
      addr_q      <= 15'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= 22'd0;
      fail_data_q <= 32'h0;
      wen_q       <= 4'h0;
      wdata_q     <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_W0;
            chk_q       <= 1'b0;
            addr_q      <= 15'd0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= 22'd0;
            fail_data_q <= 32'h0;
            wen_q       <= 4'hF;
            wdata_q     <= PATTERN;
          end
        end
        S_W0: begin
          if (addr_q == LAST) begin
            state_q <= S_R0W1;
            addr_q  <= 15'd0;
            wen_q   <= 4'h0;
            wdata_q <= 32'h0;
            chk_q   <= 1'b0;
          end else begin
            addr_q <= addr_q + 15'd1;
          end
        end
        S_R0W1, S_R1W0, S_R0: begin
          if (!chk_q) begin
            chk_q <= 1'b1;
            if (state_q == S_R0W1) begin
              wen_q   <= 4'hF;
              wdata_q <= ~PATTERN;
            end else if (state_q == S_R1W0) begin
              wen_q   <= 4'hF;
              wdata_q <= PATTERN;
            end else begin
              wen_q   <= 4'h0;
              wdata_q <= 32'h0;
            end
          end else if (mismatch_d) begin
            state_q     <= S_DONE;
            chk_q       <= 1'b0;
            fail_q      <= 1'b1;
            fail_addr_q <= {7'd0, addr_q};
            fail_data_q <= mem_rdata;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            addr_q      <= 15'd0;
            wen_q       <= 4'h0;
            wdata_q     <= 32'h0;
          end else begin
            chk_q   <= 1'b0;
            wen_q   <= 4'h0;
            wdata_q <= 32'h0;
            case (state_q)
              S_R0W1: begin
                if (addr_q == LAST) begin
                  state_q <= S_R1W0;
                  addr_q  <= LAST;
                end else begin
                  addr_q <= addr_q + 15'd1;
                end
              end
              S_R1W0: begin
                if (addr_q == 15'd0) begin
                  state_q <= S_R0;
                  addr_q  <= 15'd0;
                end else begin
                  addr_q <= addr_q - 15'd1;
                end
              end
              default: begin
                if (addr_q == LAST) begin
`ifdef SPRAM_BIST_SCRUB_EN
                  state_q <= S_SCRUB;
                  addr_q  <= 15'd0;
                  wen_q   <= 4'hF;
                  wdata_q <= 32'h0;
`else
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  addr_q  <= 15'd0;
`endif
                end else begin
                  addr_q <= addr_q + 15'd1;
                end
              end
            endcase
          end
        end
`ifdef SPRAM_BIST_SCRUB_EN
        S_SCRUB: begin
          if (addr_q == LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            addr_q  <= 15'd0;
            wen_q   <= 4'h0;
            wdata_q <= 32'h0;
          end else begin
            addr_q <= addr_q + 15'd1;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          chk_q   <= 1'b0;
          addr_q  <= 15'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          wen_q   <= 4'h0;
          wdata_q <= 32'h0;
        end
      endcase
    end
  end

  // Port drive; a failing check cancels its own write, so only the write strobe
  // and data see the live compare result.
  always_comb begin
    busy      = busy_q;
    done      = done_q;
    fail      = fail_q;
    fail_addr = fail_addr_q;
    fail_data = fail_data_q;
    mem_addr  = {7'd0, addr_q};
    if (mismatch_d) begin
      mem_wen   = 4'h0;
      mem_wdata = 32'h0;
    end else begin
      mem_wen   = wen_q;
      mem_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_spram_march_bist.sv
// Directed bench for spram_march_bist: WORDS=16 instance with fault-injecting SPRAM
// model, plus a WORDS=2 instance for the boundary address trace.
module tb_spram_march_bist;

  localparam logic [31:0] P = 32'h5555_AAAA;
`ifdef SPRAM_BIST_SCRUB_EN
  localparam int          RUN16 = 128;
  localparam int          RUN2  = 16;
  localparam logic [31:0] FINAL = 32'h0;
  localparam logic [15:0] TRACE_EXP  = 16'h4F0D;
  localparam logic [15:0] TRACE_MASK = 16'hFFFF;
`else
  localparam int          RUN16 = 112;
  localparam int          RUN2  = 14;
  localparam logic [31:0] FINAL = 32'h5555_AAAA;
  localparam logic [15:0] TRACE_EXP  = 16'h13C3;
  localparam logic [15:0] TRACE_MASK = 16'h3FFF;
`endif

  logic clk = 1'b0;
  logic resetn, start, start_2;
  logic busy, done, fail, busy_2, done_2, fail_2;
  logic [21:0] fail_addr, fail_addr_2, mem_addr, mem_addr_2;
  logic [31:0] fail_data, fail_data_2, mem_wdata, mem_wdata_2;
  logic [31:0] mem_rdata = 32'h0, mem_rdata_2 = 32'h0;
  logic [3:0]  mem_wen, mem_wen_2;

  logic [31:0] mem1 [0:31];
  logic [31:0] mem2 [0:1];
  int          fault_mode = 0;
  int          kc = 0;
  int          wr5_27 = 0;
  int          viol = 0;
  logic [15:0] trace2 = 16'h0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  logic snap_busy, snap_done, snap_fail;
  logic [21:0] snap_faddr;

  always #5 clk = ~clk;

  spram_march_bist #(.WORDS(16), .PATTERN(P)) dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_data(fail_data), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  spram_march_bist #(.WORDS(2), .PATTERN(P)) dut2 (
    .clk(clk), .resetn(resetn), .start(start_2), .busy(busy_2), .done(done_2), .fail(fail_2),
    .fail_addr(fail_addr_2), .fail_data(fail_data_2), .mem_wen(mem_wen_2), .mem_addr(mem_addr_2),
    .mem_wdata(mem_wdata_2), .mem_rdata(mem_rdata_2)
  );

  function automatic logic [31:0] rd1(input logic [21:0] a);
    logic [31:0] v;
    v = mem1[a[4:0]];
    if (fault_mode == 1 && a == 22'd5) v = v | 32'h1;
    return v;
  endfunction

  function automatic int port_bad(input logic [3:0] w, input logic [31:0] d,
                                  input logic [21:0] a, input logic b, input logic dn);
    int n;
    n = 0;
    if (w != 4'h0 && w != 4'hF) n++;
    if (w == 4'h0 && d != 32'h0) n++;
    if (a[21:15] != 7'd0) n++;
    if (b && dn) n++;
    return n;
  endfunction

  // SPRAM models with registered read, fault injection and port-rule monitoring.
  always @(posedge clk) begin
    kc <= busy ? kc + 1 : 0;
    if (mem_wen == 4'hF) begin
      if (fault_mode == 2 && mem_addr == 22'd3 && mem_wdata == P && mem1[3] == ~P)
        mem1[2] <= mem1[2] ^ 32'h8000_0000;
      mem1[mem_addr[4:0]] <= mem_wdata;
    end
    if (fault_mode == 1 && busy && kc == 27 && mem_wen != 4'h0 && mem_addr == 22'd5)
      wr5_27 <= wr5_27 + 1;
    mem_rdata <= rd1(mem_addr);
    if (mem_wen_2 == 4'hF) mem2[mem_addr_2[0]] <= mem_wdata_2;
    mem_rdata_2 <= mem2[mem_addr_2[0]];
    if (busy_2) trace2 <= {trace2[14:0], mem_addr_2[0]};
    viol <= viol + port_bad(mem_wen, mem_wdata, mem_addr, busy, done)
                 + port_bad(mem_wen_2, mem_wdata_2, mem_addr_2, busy_2, done_2);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_bist(input bit inject, output int c);
    c = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    snap_busy = busy; snap_done = done; snap_fail = fail; snap_faddr = fail_addr;
    while (busy && c < 2000) begin
      start = inject && (c == 10 || c == 50);
      c++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int bad;
    resetn = 1'b0; start = 1'b0; start_2 = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_fail", fail, 1'b0);
    check_val("rst_faddr", fail_addr, 22'd0);
    check_val("rst_fdata", fail_data, 32'h0);
    check_val("rst_wen", mem_wen, 4'h0);
    check_val("rst_addr", mem_addr, 22'd0);
    check_val("rst_wdata", mem_wdata, 32'h0);
    resetn = 1'b1;

    run_bist(1'b0, cyc);
    check_val("clean_cycles", cyc, RUN16);
    check_val("clean_done", done, 1'b1);
    check_val("clean_fail", fail, 1'b0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem1[i] !== FINAL) bad++;
    check_val("clean_contents", bad, 0);

    fault_mode = 2;
    run_bist(1'b0, cyc);
    check_val("cpl_cycles", cyc, 76);
    check_val("cpl_fail", fail, 1'b1);
    check_val("cpl_faddr", fail_addr, 22'd2);
    check_val("cpl_fdata", fail_data, 32'h2AAA_5555);

    fault_mode = 1;
    run_bist(1'b0, cyc);
    check_val("sa1_cycles", cyc, 28);
    check_val("sa1_done", done, 1'b1);
    check_val("sa1_fail", fail, 1'b1);
    check_val("sa1_faddr", fail_addr, 22'd5);
    check_val("sa1_fdata", fail_data, 32'h5555_AAAB);
    check_val("sa1_no_write", wr5_27, 0);

    fault_mode = 0;
    run_bist(1'b1, cyc);
    check_val("restart_done_clr", snap_done, 1'b0);
    check_val("restart_fail_clr", snap_fail, 1'b0);
    check_val("restart_faddr_clr", snap_faddr, 22'd0);
    check_val("restart_busy", snap_busy, 1'b1);
    check_val("busy_start_cycles", cyc, RUN16);
    check_val("busy_start_fail", fail, 1'b0);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    check_val("mid_busy_before", busy, 1'b1);
    resetn = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_done", done, 1'b0);
    check_val("mid_rst_fail", fail, 1'b0);
    check_val("mid_rst_wen", mem_wen, 4'h0);
    @(negedge clk); resetn = 1'b1;
    run_bist(1'b0, cyc);
    check_val("rerun_cycles", cyc, RUN16);
    check_val("rerun_done", done, 1'b1);
    check_val("rerun_fail", fail, 1'b0);

    @(negedge clk); start_2 = 1'b1;
    @(negedge clk); start_2 = 1'b0;
    cyc = 0;
    while (busy_2 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    check_val("w2_cycles", cyc, RUN2);
    check_val("w2_done", done_2, 1'b1);
    check_val("w2_fail", fail_2, 1'b0);
    check_val("w2_trace", trace2 & TRACE_MASK, TRACE_EXP);
    check_val("w2_word0", mem2[0], FINAL);
    check_val("w2_word1", mem2[1], FINAL);

    @(negedge clk);
    check_val("port_rules", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
